qam16_herm_mapper: RTL and testbench
====================================

QAM16_HERM_MAPPER -- requirements
Module: qam16_herm_mapper

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter N_SC, default 31: data subcarriers per OFDM frame.
REQ-003 Parameter SCALE, default 32: amplitude of unit constellation level; outputs are 8-bit two's complement.
REQ-004 Port clk, input, 1: rising-edge clock.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port bit_in, input, 1: serial payload bit.
REQ-007 Port bit_valid, input, 1: bit_in is accepted on a clock edge where this is high.
REQ-008 Port frame_sync, input, 1: abort the partial symbol and restart the subcarrier index at 0.
REQ-009 Port re_out, output, 8: in-phase value, signed.
REQ-010 Port im_out, output, 8: quadrature value, signed.
REQ-011 Port re_out_conj, output, 8: conjugate real part, equal to re_out.
REQ-012 Port im_out_conj, output, 8: conjugate imaginary part, equal to -im_out.
REQ-013 Port sym_valid, output, 1: one-cycle strobe; all four data outputs are valid in that cycle.
REQ-014 Port sc_idx, output, 5: subcarrier index of the current symbol, 0..N_SC-1.
REQ-015 Port frame_last, output, 1: strobe coincident with sym_valid when sc_idx = N_SC-1.

Function
REQ-016 Bits SHALL be gathered MSB-first into a 4-bit shift register.
- A 2-bit counter, bit_cnt, tracks accepted bits 0..3.
- bit_cnt advances only on bit_valid.
REQ-017 State machine SHALL have two states, COLLECT and EMIT.
- COLLECT → EMIT: edge accepting the 4th bit (bit_cnt = 3).
- EMIT → COLLECT: always after one cycle.
REQ-018 In EMIT, sym_valid SHALL be 1, so latency is exactly one clock from the 4th accepted bit to sym_valid.
REQ-019 Mapping SHALL use Gray-coded levels for b3b2 → I and b1b0 → Q, with outputs equal to level × SCALE:
- 00 → -3
- 01 → -1
- 11 → +1
- 10 → +3
REQ-020 With SCALE = 32, the output values SHALL be -96 (0xA0), -32 (0xE0), +32 (0x20) and +96 (0x60).
- Arithmetic is 8-bit two's complement.
- No saturation is required for SCALE ≤ 42.
REQ-021 im_out_conj SHALL be the 8-bit two's-complement negation of the im_out value presented in the same cycle.
REQ-022 Data outputs SHALL hold their last values while sym_valid = 0.
REQ-023 A bit_valid arriving during EMIT SHALL be accepted as bit 0 of the next symbol, with no bubble.
- Sustained 1 bit/clk therefore yields a sym_valid every 4 cycles.
REQ-024 sc_idx SHALL advance after each sym_valid and wrap from N_SC-1 to 0.
- frame_last is asserted only with the symbol at index N_SC-1.
REQ-025 When frame_sync = 1 on an edge, the block SHALL:
- clear bit_cnt;
- set sc_idx to 0;
- return to COLLECT.
- If in EMIT, the pending symbol is still output in that cycle.
REQ-026 When frame_sync and bit_valid are both 1 on one edge, sync SHALL act first.
- That bit becomes bit 0 of a new symbol.
REQ-027 Mid-frame gaps in bit_valid SHALL NOT alter state.
- There is no timeout.

Reset
REQ-028 While reset = 1 on an edge, the block SHALL set all outputs to 0:
- re_out, im_out, re_out_conj, im_out_conj, sym_valid, sc_idx, frame_last.
- bit_cnt is cleared and the state is COLLECT.
- Reset overrides bit_valid and frame_sync.
REQ-029 Reset asserted mid-symbol or mid-frame SHALL discard partial bits.
- The first symbol after reset has sc_idx = 0.

Verification
REQ-030 Bits 1,0,1,1 at 1 bit/clk → one cycle after the 4th bit:
- sym_valid = 1, sc_idx = 0;
- re_out = re_out_conj = 0x60;
- im_out = 0x20, im_out_conj = 0xE0.
REQ-031 All 16 nibbles 0000..1111 back-to-back:
- 16 sym_valid pulses spaced 4 cycles apart;
- each output matches REQ-019;
- sc_idx runs 0..15.
REQ-032 124 continuous bits (31 symbols) → frame_last is high only with the 31st sym_valid (sc_idx = 30).
- The 32nd symbol reports sc_idx = 0.
REQ-033 Feed 2 bits, assert frame_sync together with bit 1, then feed bits 0,0,0:
- the symbol 1000 maps to re = 0x60, im = 0xA0;
- sc_idx = 0.
REQ-034 Reset asserted after 50 bits:
- all outputs read 0 on the next cycle;
- the next 4 bits produce sc_idx = 0.
REQ-035 Bits with bit_valid toggling 1,0,0,1,0,1,1 → sym_valid appears exactly one cycle after the 4th bit_valid high.

Source files
------------

// File: rtl/qam16_herm_mapper.sv
// ----------------------------------------------------------------------------
// qam16_herm_mapper
//
// Serial-to-16-QAM mapper that also emits the complex conjugate of each
// symbol, so a downstream IFFT can fill the Hermitian-mirrored half of an
// OFDM frame from the same output.
//
// Bits are collected MSB-first in groups of four. b3b2 selects the in-phase
// level and b1b0 selects the quadrature level. Both use the Gray-coded map
// 00 -> -3, 01 -> -1, 11 -> +1, 10 -> +3. Each level is multiplied by SCALE
// and presented as 8-bit two's complement.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   bit_in       serial payload bit
//   bit_valid    bit_in is accepted on an edge where this is high
//   frame_sync   drop any partial symbol and restart the subcarrier index at 0
//   re_out       in-phase value (signed)
//   im_out       quadrature value (signed)
//   re_out_conj  conjugate real part, equal to re_out
//   im_out_conj  conjugate imaginary part, equal to -im_out
//   sym_valid    one-cycle strobe; the four data outputs are valid with it
//   sc_idx       subcarrier index of the current symbol, 0..N_SC-1
//   frame_last   strobe with sym_valid for the symbol at index N_SC-1
// ----------------------------------------------------------------------------
module qam16_herm_mapper #(
    parameter int N_SC  = 31,
    parameter int SCALE = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       bit_in,
    input  logic       bit_valid,
    input  logic       frame_sync,
    output logic [7:0] re_out,
    output logic [7:0] im_out,
    output logic [7:0] re_out_conj,
    output logic [7:0] im_out_conj,
    output logic       sym_valid,
    output logic [4:0] sc_idx,
    output logic       frame_last
);

    localparam logic [4:0] LAST_IDX = 5'(N_SC - 1);

    // Constellation amplitudes. SCALE <= 42 keeps 3*SCALE inside 8 bits.
    localparam logic [7:0] LVL_P1 = 8'(SCALE);
    localparam logic [7:0] LVL_P3 = 8'(3 * SCALE);
    localparam logic [7:0] LVL_N1 = 8'(-SCALE);
    localparam logic [7:0] LVL_N3 = 8'(-3 * SCALE);

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } state_t;

    state_t     state_reg, state_next;
    logic [3:0] shift_reg, shift_next;
    logic [1:0] bit_cnt_reg, bit_cnt_next;
    logic [4:0] sc_idx_reg, sc_idx_next;
    logic [7:0] re_reg, im_reg, im_conj_reg;
    logic       sym_done;

    // The nibble as it would stand once the bit presented now is shifted in.
    // On the edge that accepts bit 3 this is the full symbol.
    logic [3:0]      nibble;
    logic [1:0][7:0] lvl;   // lvl[1] = I (b3b2), lvl[0] = Q (b1b0)

    assign nibble = {shift_reg[2:0], bit_in};

    function automatic logic [7:0] gray_level(input logic [1:0] code);
        logic [7:0] val;
        case (code)
            2'b00:   val = LVL_N3;
            2'b01:   val = LVL_N1;
            2'b11:   val = LVL_P1;
            default: val = LVL_P3;
        endcase
        return val;
    endfunction

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            assign lvl[gi] = gray_level(nibble[2*gi+1 -: 2]);
        end
    endgenerate

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= COLLECT;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            sc_idx_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
            sc_idx_reg  <= sc_idx_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. EMIT always lasts one cycle. A bit arriving during
    // EMIT is taken as bit 0 of the next symbol. This is possible because
    // bit_cnt has already wrapped to 0 on the edge that entered EMIT.
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = COLLECT;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        sc_idx_next  = sc_idx_reg;
        sym_done     = 1'b0;

        // The symbol shown in EMIT consumes its index as EMIT ends.
        if (state_reg == EMIT) begin
            sc_idx_next = (sc_idx_reg == LAST_IDX) ? 5'd0 : sc_idx_reg + 5'd1;
        end

        if (bit_valid) begin
            shift_next = nibble;
        end

        if (frame_sync) begin
            // The sync takes effect first. A bit on the same edge starts a
            // fresh symbol.
            sc_idx_next  = 5'd0;
            bit_cnt_next = bit_valid ? 2'd1 : 2'd0;
        end else if (bit_valid) begin
            bit_cnt_next = bit_cnt_reg + 2'd1;
            if (bit_cnt_reg == 2'd3) begin
                sym_done   = 1'b1;
                state_next = EMIT;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output data registers. They load only when a symbol completes, and
    // they hold their values between strobes.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            re_reg      <= '0;
            im_reg      <= '0;
            im_conj_reg <= '0;
        end else if (sym_done) begin
            re_reg      <= lvl[1];
            im_reg      <= lvl[0];
            im_conj_reg <= 8'd0 - lvl[0];
        end
    end

    assign re_out      = re_reg;
    assign im_out      = im_reg;
    assign re_out_conj = re_reg;
    assign im_out_conj = im_conj_reg;
    assign sym_valid   = (state_reg == EMIT);
    assign sc_idx      = sc_idx_reg;
    assign frame_last  = (state_reg == EMIT) && (sc_idx_reg == LAST_IDX);

endmodule

// File: tb/tb_qam16_herm_mapper.sv
// ----------------------------------------------------------------------------
// tb_qam16_herm_mapper
//
// Directed bench for qam16_herm_mapper with the default parameters
// (N_SC = 31, SCALE = 32). One step is applied per clock. Inputs are driven
// 1 ns after the rising edge, and outputs are sampled 1 ns after the edge
// that follows.
//
// Ports: none (top-level bench).
// ----------------------------------------------------------------------------
module tb_qam16_herm_mapper;

    logic       clk;
    logic       reset;
    logic       bit_in;
    logic       bit_valid;
    logic       frame_sync;
    logic [7:0] re_out;
    logic [7:0] im_out;
    logic [7:0] re_out_conj;
    logic [7:0] im_out_conj;
    logic       sym_valid;
    logic [4:0] sc_idx;
    logic       frame_last;

    int n_vec;
    int n_err;

    qam16_herm_mapper #(
        .N_SC  (31),
        .SCALE (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .frame_sync  (frame_sync),
        .re_out      (re_out),
        .im_out      (im_out),
        .re_out_conj (re_out_conj),
        .im_out_conj (im_out_conj),
        .sym_valid   (sym_valid),
        .sc_idx      (sc_idx),
        .frame_last  (frame_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-written Gray map for SCALE = 32.
    function automatic logic [7:0] exp_level(input logic [1:0] code);
        case (code)
            2'b00:   return 8'hA0;
            2'b01:   return 8'hE0;
            2'b11:   return 8'h20;
            default: return 8'h60;
        endcase
    endfunction

    function automatic logic [7:0] exp_neg(input logic [7:0] v);
        case (v)
            8'hA0:   return 8'h60;
            8'hE0:   return 8'h20;
            8'h20:   return 8'hE0;
            8'h60:   return 8'hA0;
            default: return 8'h00;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic b, input logic fs);
        bit_valid  = v;
        bit_in     = b;
        frame_sync = fs;
        @(posedge clk);
        #1;
        bit_valid  = 1'b0;
        frame_sync = 1'b0;
    endtask

    task automatic chk_symbol(input string tag, input logic [3:0] n,
                              input logic [4:0] idx, input logic last);
        logic [7:0] ei;
        logic [7:0] eq;
        ei = exp_level(n[3:2]);
        eq = exp_level(n[1:0]);
        chk({tag, "_sv"}, 8'(sym_valid), 8'd1);
        chk({tag, "_re"}, re_out, ei);
        chk({tag, "_im"}, im_out, eq);
        chk({tag, "_rec"}, re_out_conj, ei);
        chk({tag, "_imc"}, im_out_conj, exp_neg(eq));
        chk({tag, "_idx"}, 8'(sc_idx), 8'(idx));
        chk({tag, "_last"}, 8'(frame_last), 8'(last));
        $display("symbol %s nibble=%b idx=%0d re=%02h im=%02h", tag, n, sc_idx, re_out, im_out);
    endtask

    task automatic send_nibble(input string tag, input logic [3:0] n,
                               input logic [4:0] idx, input logic last);
        for (int k = 3; k >= 0; k--) begin
            step(1'b1, n[k], 1'b0);
            if (k != 0) chk({tag, "_nosv"}, 8'(sym_valid), 8'd0);
        end
        chk_symbol(tag, n, idx, last);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_re"}, re_out, 8'h00);
        chk({tag, "_im"}, im_out, 8'h00);
        chk({tag, "_rec"}, re_out_conj, 8'h00);
        chk({tag, "_imc"}, im_out_conj, 8'h00);
        chk({tag, "_sv"}, 8'(sym_valid), 8'd0);
        chk({tag, "_idx"}, 8'(sc_idx), 8'd0);
        chk({tag, "_last"}, 8'(frame_last), 8'd0);
    endtask

    initial begin
        logic [3:0] gap_v;
        n_vec      = 0;
        n_err      = 0;
        reset      = 1'b1;
        bit_in     = 1'b0;
        bit_valid  = 1'b0;
        frame_sync = 1'b0;

        // Reset state. bit_valid and frame_sync are asserted to confirm that
        // reset overrides them.
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        chk_all_zero("reset");
        reset = 1'b0;

        // Single symbol 1011.
        send_nibble("first", 4'b1011, 5'd0, 1'b0);

        // All 16 nibbles back-to-back after a fresh reset.
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send_nibble("all16", 4'(i), 5'(i), 1'b0);
        end

        // A full frame of 31 symbols, then wrap to index 0.
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 31; i++) begin
            send_nibble("frame", 4'(15 - (i % 16)), 5'(i), (i == 30));
        end
        send_nibble("wrap", 4'b0110, 5'd0, 1'b0);

        // frame_sync arrives with a bit after two bits. The index is at 1.
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        chk("sync_nosv", 8'(sym_valid), 8'd0);
        chk("sync_idx", 8'(sc_idx), 8'd0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("sync_nosv2", 8'(sym_valid), 8'd0);
        step(1'b1, 1'b0, 1'b0);
        chk_symbol("sync", 4'b1000, 5'd0, 1'b0);

        // frame_sync during EMIT: the symbol above has already been shown,
        // and the index restarts at 0 rather than advancing to 1.
        step(1'b1, 1'b1, 1'b1);
        chk("esync_nosv", 8'(sym_valid), 8'd0);
        chk("esync_idx", 8'(sc_idx), 8'd0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk_symbol("esync", 4'b1010, 5'd0, 1'b0);

        // Gapped bit_valid pattern 1,0,0,1,0,1,1 carrying bits 0,1,1,0.
        // Outputs hold the previous symbol's values during the gaps.
        gap_v = 4'b0110;
        step(1'b1, gap_v[3], 1'b0);
        chk("gap0_nosv", 8'(sym_valid), 8'd0);
        chk("gap0_hold", re_out, 8'h60);
        step(1'b0, 1'b1, 1'b0);
        chk("gap1_nosv", 8'(sym_valid), 8'd0);
        step(1'b0, 1'b0, 1'b0);
        chk("gap2_nosv", 8'(sym_valid), 8'd0);
        chk("gap2_hold", im_out, 8'h60);
        step(1'b1, gap_v[2], 1'b0);
        chk("gap3_nosv", 8'(sym_valid), 8'd0);
        step(1'b0, 1'b0, 1'b0);
        chk("gap4_nosv", 8'(sym_valid), 8'd0);
        step(1'b1, gap_v[1], 1'b0);
        chk("gap5_nosv", 8'(sym_valid), 8'd0);
        step(1'b1, gap_v[0], 1'b0);
        chk_symbol("gap", 4'b0110, 5'd1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("gap_strobe_end", 8'(sym_valid), 8'd0);
        chk("gap_hold_imc", im_out_conj, 8'hA0);

        // Reset after 50 bits: 12 symbols plus 2 partial bits are discarded.
        for (int i = 0; i < 50; i++) begin
            step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        end
        reset = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        reset = 1'b0;
        chk_all_zero("midreset");
        send_nibble("postreset", 4'b0000, 5'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
